// File: rtl/crtg_pkg.sv
// Shared types and helpers for the compacting random-test-generation engine.
package crtg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_OFFER,
        ST_SCAN,
        ST_DECIDE,
        ST_EMIT,
        ST_DONE
    } state_e;

    localparam logic [1:0] REASON_COV   = 2'd0;
    localparam logic [1:0] REASON_UT    = 2'd1;
    localparam logic [1:0] REASON_PROTO = 2'd2;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned cw_of(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'd0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/crtg_adaptive_engine_if.sv
// Vector offer, fault-detect stream and kept-vector stream between the engine and its harness.
interface crtg_adaptive_engine_if #(
    parameter int unsigned VEC_W = 157
);
    logic [VEC_W-1:0] vec_data;
    logic             vec_valid;
    logic             vec_ready;
    logic             det_valid;
    logic             det_bit;
    logic             det_last;
    logic [VEC_W-1:0] keep_data;
    logic             keep_valid;
    logic             keep_ready;

    modport master (
        output vec_data, vec_valid, keep_data, keep_valid,
        input  vec_ready, det_valid, det_bit, det_last, keep_ready
    );

    modport slave (
        input  vec_data, vec_valid, keep_data, keep_valid,
        output vec_ready, det_valid, det_bit, det_last, keep_ready
    );
endinterface

// File: rtl/crtg_lfsr32.sv
// 32-bit Galois LFSR; reset loads the seed, o_word is the current state.
module crtg_lfsr32
    import crtg_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [31:0] o_word
);
    // An all-zero seed would lock the register, so it is replaced by 1
    localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED_NZ;
        end else if (i_en) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_word = r_state;
endmodule

// File: rtl/crtg_adaptive_engine.sv
// Generates random vectors, scores them against harness detect bits and keeps
// only those that add enough new faults; the threshold halves per coverage step.
module crtg_adaptive_engine
    import crtg_pkg::*;
#(
    parameter int unsigned VEC_W       = 157,
    parameter int unsigned NUM_FAULTS  = 1798,
    parameter int unsigned UT_LIMIT    = 20,
    parameter int unsigned DESIRED_COV = 90,
    parameter int unsigned COV_STEP    = 10,
    parameter int unsigned EXP_DIV     = 20,
    parameter logic [31:0] SEED        = 32'hACE1_0001
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    crtg_adaptive_engine_if.master           bus,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [1:0]                       o_done_reason,
    output logic [CNT_W-1:0]                 o_kept_cnt,
    output logic [CNT_W-1:0]                 o_total_cnt,
    output logic [cw_of(NUM_FAULTS)-1:0]     o_det_total
);
    localparam int unsigned CW  = cw_of(NUM_FAULTS);
    localparam int unsigned IW  = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
    localparam int unsigned NW  = (VEC_W + 31) / 32;
    localparam int unsigned GW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned EW  = 16;
    localparam logic [CW-1:0]  EXP_INIT  = CW'(NUM_FAULTS / EXP_DIV);
    localparam logic [31:0]    GOAL_PROD = 32'(DESIRED_COV * NUM_FAULTS);
    localparam logic [31:0]    NF_32     = 32'(NUM_FAULTS);

    state_e r_state;
    state_e w_state_next;
    logic [1:0] w_reason_next;

    logic [VEC_W-1:0]      r_vec;
    logic [VEC_W-1:0]      r_keep_data;
    logic                  r_vec_valid;
    logic                  r_keep_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            r_reason;
    logic [CNT_W-1:0]      r_kept_cnt;
    logic [CNT_W-1:0]      r_total_cnt;
    logic [CNT_W-1:0]      r_useless;
    logic [CW-1:0]         r_det_total;
    logic [CW-1:0]         r_new_cnt;
    logic [CW-1:0]         r_exp_cnt;
    logic [EW-1:0]         r_cov_edge;
    logic [NUM_FAULTS-1:0] r_at_map;
    logic [NUM_FAULTS-1:0] r_ct_map;
    logic [IW-1:0]         r_idx;
    logic [GW-1:0]         r_word_idx;

    logic              w_lfsr_en;
    logic [31:0]       w_lfsr_word;
    logic              w_start_ok;
    logic              w_last_word;
    logic              w_idx_last;
    logic              w_keep;
    logic [CW-1:0]     w_det_sum;
    logic [CNT_W-1:0]  w_useless_inc;
    logic              w_cov_step_hit;
    logic              w_goal_hit;
    logic              w_ut_hit;

    assign w_lfsr_en = (r_state == ST_GEN);

    crtg_lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_lfsr_en),
        .o_word (w_lfsr_word)
    );

    // Faults counted in new_cnt are absent from at_map, so the sum never exceeds NUM_FAULTS
    assign w_start_ok     = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_word    = (r_word_idx == GW'(NW - 1));
    assign w_idx_last     = (r_idx == IW'(NUM_FAULTS - 1));
    assign w_keep         = (r_new_cnt >= r_exp_cnt) && (r_new_cnt != '0);
    assign w_det_sum      = r_det_total + r_new_cnt;
    assign w_useless_inc  = sat_inc(r_useless);
    assign w_cov_step_hit = (32'(w_det_sum) * 32'd100) >= (32'(r_cov_edge) * NF_32);
    assign w_goal_hit     = (32'(r_det_total) * 32'd100) >= GOAL_PROD;
    assign w_ut_hit       = (w_useless_inc >= CNT_W'(UT_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_reason_next = r_reason;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_next  = ST_GEN;
                    w_reason_next = REASON_COV;
                end
            end
            ST_GEN: begin
                if (w_last_word) w_state_next = ST_OFFER;
            end
            ST_OFFER: begin
                if (bus.vec_ready) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                // det_last must coincide exactly with the final fault index
                if (bus.det_valid) begin
                    if (bus.det_last != w_idx_last) begin
                        w_state_next  = ST_DONE;
                        w_reason_next = REASON_PROTO;
                    end else if (bus.det_last) begin
                        w_state_next = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                if (w_keep) begin
                    w_state_next = ST_EMIT;
                end else if (w_goal_hit) begin
                    w_state_next  = ST_DONE;
                    w_reason_next = REASON_COV;
                end else if (w_ut_hit) begin
                    w_state_next  = ST_DONE;
                    w_reason_next = REASON_UT;
                end else begin
                    w_state_next = ST_GEN;
                end
            end
            ST_EMIT: begin
                if (bus.keep_ready) begin
                    if (w_goal_hit) begin
                        w_state_next  = ST_DONE;
                        w_reason_next = REASON_COV;
                    end else if (r_useless >= CNT_W'(UT_LIMIT)) begin
                        w_state_next  = ST_DONE;
                        w_reason_next = REASON_UT;
                    end else begin
                        w_state_next = ST_GEN;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec        <= '0;
            r_keep_data  <= '0;
            r_vec_valid  <= 1'b0;
            r_keep_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_reason     <= 2'd0;
            r_kept_cnt   <= '0;
            r_total_cnt  <= '0;
            r_useless    <= '0;
            r_det_total  <= '0;
            r_new_cnt    <= '0;
            r_exp_cnt    <= EXP_INIT;
            r_cov_edge   <= EW'(COV_STEP);
            r_at_map     <= '0;
            r_ct_map     <= '0;
            r_idx        <= '0;
            r_word_idx   <= '0;
        end else begin
            r_vec_valid  <= (w_state_next == ST_OFFER);
            r_keep_valid <= (w_state_next == ST_EMIT);
            r_busy       <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
            r_done       <= (w_state_next == ST_DONE);
            r_reason     <= w_reason_next;

            if (w_start_ok) begin
                r_kept_cnt  <= '0;
                r_total_cnt <= '0;
                r_useless   <= '0;
                r_det_total <= '0;
                r_exp_cnt   <= EXP_INIT;
                r_cov_edge  <= EW'(COV_STEP);
                r_at_map    <= '0;
                r_ct_map    <= '0;
                r_word_idx  <= '0;
            end

            // Earlier words shift toward the top and the oldest bits fall off
            if (r_state == ST_GEN) begin
                r_vec      <= VEC_W'({r_vec, w_lfsr_word});
                r_word_idx <= w_last_word ? '0 : r_word_idx + GW'(1);
                if (w_last_word) r_total_cnt <= sat_inc(r_total_cnt);
            end

            if ((r_state == ST_OFFER) && bus.vec_ready) begin
                r_ct_map  <= '0;
                r_idx     <= '0;
                r_new_cnt <= '0;
            end

            if ((r_state == ST_SCAN) && bus.det_valid) begin
                r_ct_map[r_idx] <= bus.det_bit;
                r_idx           <= r_idx + IW'(1);
                if (bus.det_bit && !r_at_map[r_idx]) r_new_cnt <= r_new_cnt + CW'(1);
            end

            if (r_state == ST_DECIDE) begin
                if (w_keep) begin
                    r_at_map    <= r_at_map | r_ct_map;
                    r_det_total <= w_det_sum;
                    r_kept_cnt  <= sat_inc(r_kept_cnt);
                    r_useless   <= '0;
                    r_keep_data <= r_vec;
                    if (w_cov_step_hit) begin
                        r_cov_edge <= r_cov_edge + EW'(COV_STEP);
                        r_exp_cnt  <= r_exp_cnt >> 1;
                    end
                end else begin
                    r_useless <= w_useless_inc;
                end
            end
        end
    end

    assign bus.vec_data   = r_vec;
    assign bus.vec_valid  = r_vec_valid;
    assign bus.keep_data  = r_keep_data;
    assign bus.keep_valid = r_keep_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_done_reason  = r_reason;
    assign o_kept_cnt     = r_kept_cnt;
    assign o_total_cnt    = r_total_cnt;
    assign o_det_total    = r_det_total;
endmodule

// File: tb/tb_crtg_adaptive_engine.sv
// Directed bench: small fault list, table of per-vector detect patterns plus reset/stall sequences.
module tb_crtg_adaptive_engine;
    localparam int unsigned VEC_W = 40;
    localparam int unsigned NF    = 10;
    localparam int unsigned CW    = 4;
    localparam logic [31:0] SEED_V = 32'hACE1_0001;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_done_reason;
    logic [15:0]   o_kept_cnt;
    logic [15:0]   o_total_cnt;
    logic [CW-1:0] o_det_total;

    crtg_adaptive_engine_if #(.VEC_W(VEC_W)) bus ();

    crtg_adaptive_engine #(
        .VEC_W(VEC_W), .NUM_FAULTS(NF), .UT_LIMIT(3), .DESIRED_COV(90),
        .COV_STEP(10), .EXP_DIV(5), .SEED(SEED_V)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .bus(bus),
        .o_busy(o_busy), .o_done(o_done), .o_done_reason(o_done_reason),
        .o_kept_cnt(o_kept_cnt), .o_total_cnt(o_total_cnt), .o_det_total(o_det_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          restart;
        logic [9:0]  det;
        int          last_at;
        bit          stall;
        bit          exp_keep;
        logic [3:0]  exp_dt;
        logic [15:0] exp_kept;
        logic [15:0] exp_total;
        bit          exp_done;
        logic [1:0]  exp_reason;
    } row_t;

    row_t        rows [10];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Model: word k is the LFSR state before its k-th step, older words land higher
    task automatic gen_model(output logic [39:0] v);
        logic [63:0] acc;
        acc = '0;
        for (int w = 0; w < 2; w++) begin
            acc = {acc[31:0], m_s};
            m_s = lfsr_next(m_s);
        end
        v = acc[39:0];
    endtask

    task automatic wait_vec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.vec_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   64'(o_busy), 64'd0);
        check({tag, "_done"},   64'(o_done), 64'd0);
        check({tag, "_reason"}, 64'(o_done_reason), 64'd0);
        check({tag, "_kept"},   64'(o_kept_cnt), 64'd0);
        check({tag, "_total"},  64'(o_total_cnt), 64'd0);
        check({tag, "_dtot"},   64'(o_det_total), 64'd0);
        check({tag, "_vvalid"}, 64'(bus.vec_valid), 64'd0);
        check({tag, "_kvalid"}, 64'(bus.keep_valid), 64'd0);
        check({tag, "_vdata"},  64'(bus.vec_data), 64'd0);
        check({tag, "_kdata"},  64'(bus.keep_data), 64'd0);
    endtask

    task automatic run_row(input int idx, input row_t r);
        logic [39:0] v;
        bit ok;
        bit saw_keep;
        if (r.restart) begin
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        wait_vec(ok);
        check($sformatf("r%0d_vec_valid", idx), 64'(ok), 64'd1);
        gen_model(v);
        check($sformatf("r%0d_vec_data", idx), 64'(bus.vec_data), 64'(v));
        check($sformatf("r%0d_total", idx), 64'(o_total_cnt), 64'(r.exp_total));
        bus.vec_ready = 1'b1;
        tick();
        bus.vec_ready = 1'b0;
        // Start pulsed on the first beat must be ignored while busy
        for (int i = 0; i < int'(NF); i++) begin
            bus.det_valid = 1'b1;
            bus.det_bit   = r.det[i];
            bus.det_last  = (i == r.last_at);
            i_start       = (i == 0);
            tick();
            if (i == r.last_at) break;
        end
        bus.det_valid = 1'b0;
        bus.det_bit   = 1'b0;
        bus.det_last  = 1'b0;
        i_start       = 1'b0;
        saw_keep = 1'b0;
        ok       = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            if (bus.keep_valid) begin
                saw_keep = 1'b1;
                check($sformatf("r%0d_keep_data", idx), 64'(bus.keep_data), 64'(v));
                if (r.stall) begin
                    for (int s = 0; s < 3; s++) begin
                        tick();
                        check($sformatf("r%0d_stall_kvalid", idx), 64'(bus.keep_valid), 64'd1);
                        check($sformatf("r%0d_stall_kdata", idx), 64'(bus.keep_data), 64'(v));
                    end
                end
                bus.keep_ready = 1'b1;
                tick();
                bus.keep_ready = 1'b0;
            end else if (bus.vec_valid || o_done) begin
                ok = 1'b1;
            end else begin
                tick();
            end
        end
        check($sformatf("r%0d_settle", idx), 64'(ok), 64'd1);
        check($sformatf("r%0d_kept_flag", idx), 64'(saw_keep), 64'(r.exp_keep));
        check($sformatf("r%0d_det_total", idx), 64'(o_det_total), 64'(r.exp_dt));
        check($sformatf("r%0d_kept_cnt", idx), 64'(o_kept_cnt), 64'(r.exp_kept));
        check($sformatf("r%0d_done", idx), 64'(o_done), 64'(r.exp_done));
        check($sformatf("r%0d_busy", idx), 64'(o_busy), 64'(!r.exp_done));
        check($sformatf("r%0d_reason", idx), 64'(o_done_reason), 64'(r.exp_reason));
    endtask

    initial begin
        logic [39:0] v;
        bit ok;

        //          rst  det            last st kp dt     kept   total  done reason
        rows[0] = '{1'b1, 10'b0000000111, 9, 1'b1, 1'b1, 4'd3, 16'd1, 16'd1, 1'b0, 2'd0};
        rows[1] = '{1'b0, 10'b0000000110, 9, 1'b0, 1'b0, 4'd3, 16'd1, 16'd2, 1'b0, 2'd0};
        rows[2] = '{1'b0, 10'b0000100000, 9, 1'b0, 1'b1, 4'd4, 16'd2, 16'd3, 1'b0, 2'd0};
        rows[3] = '{1'b0, 10'b0000000001, 9, 1'b0, 1'b0, 4'd4, 16'd2, 16'd4, 1'b0, 2'd0};
        rows[4] = '{1'b0, 10'b0111011000, 9, 1'b0, 1'b1, 4'd9, 16'd3, 16'd5, 1'b1, 2'd0};
        rows[5] = '{1'b1, 10'b0000000000, 9, 1'b0, 1'b0, 4'd0, 16'd0, 16'd1, 1'b0, 2'd0};
        rows[6] = '{1'b0, 10'b0000000000, 9, 1'b0, 1'b0, 4'd0, 16'd0, 16'd2, 1'b0, 2'd0};
        rows[7] = '{1'b0, 10'b0000000000, 9, 1'b0, 1'b0, 4'd0, 16'd0, 16'd3, 1'b1, 2'd1};
        rows[8] = '{1'b1, 10'b0000011111, 4, 1'b0, 1'b0, 4'd0, 16'd0, 16'd1, 1'b1, 2'd2};
        rows[9] = '{1'b1, 10'b0000000000, -1, 1'b0, 1'b0, 4'd0, 16'd0, 16'd1, 1'b1, 2'd2};

        m_s            = SEED_V;
        rst            = 1'b1;
        i_start        = 1'b0;
        bus.vec_ready  = 1'b0;
        bus.det_valid  = 1'b0;
        bus.det_bit    = 1'b0;
        bus.det_last   = 1'b0;
        bus.keep_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(o_busy), 64'd0);

        for (int i = 0; i < 10; i++) run_row(i, rows[i]);

        // Reset in the middle of a scan aborts to reset values and reloads the seed
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_vec(ok);
        check("mid_vec_valid", 64'(ok), 64'd1);
        gen_model(v);
        check("mid_vec_data", 64'(bus.vec_data), 64'(v));
        bus.vec_ready = 1'b1;
        tick();
        bus.vec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.det_valid = 1'b1;
            bus.det_bit   = 1'b1;
            tick();
        end
        bus.det_valid = 1'b0;
        bus.det_bit   = 1'b0;
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 64'(o_busy), 64'd0);
        check("post_rst_done", 64'(o_done), 64'd0);
        m_s = SEED_V;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_vec(ok);
        check("reseed_vec_valid", 64'(ok), 64'd1);
        gen_model(v);
        check("reseed_vec_data", 64'(bus.vec_data), 64'(v));
        check("reseed_total", 64'(o_total_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/crtg_adaptive_engine.md
Name: crtg_adaptive_engine

Overview:
Synthesizable compacting random-test-generation (CRTG) engine.
- Generates pseudo-random test vectors and presents each one to an external fault-simulation harness.
- Receives one detect bit per fault from the harness.
- Keeps a vector only when it finds enough new faults; the acceptance threshold halves at each coverage step.
- Sits between the pattern source and the fault-sim / tester output FIFO; parametrised in vector width, fault count and stop criteria.

Parameters:
VEC_W, 157, test vector width in bits
NUM_FAULTS, 1798, faults per scan (fault-list length)
UT_LIMIT, 20, consecutive rejected vectors before stop
DESIRED_COV, 90, target coverage, percent
COV_STEP, 10, coverage step, percent, at which the threshold halves
EXP_DIV, 20, initial threshold = NUM_FAULTS/EXP_DIV
SEED, 32'hACE1_0001, LFSR seed (must be nonzero)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begins a run when idle
vec_data  out  VEC_W  candidate vector to fault sim
vec_valid  out  1  vector valid
vec_ready  in  1  fault sim accepts vector
det_valid  in  1  detect bit valid
det_bit  in  1  fault[idx] detected by current vector
det_last  in  1  marks last fault of scan
keep_data  out  VEC_W  accepted vector
keep_valid  out  1  accepted vector valid
keep_ready  in  1  sink accepts
busy  out  1  run in progress
done  out  1  run finished, sticky until next start
done_reason  out  2  0 coverage reached, 1 UT_LIMIT hit, 2 protocol error
kept_cnt  out  16  vectors kept
total_cnt  out  16  vectors generated
det_total  out  CW  faults detected all-time, CW=$clog2(NUM_FAULTS+1)

Behaviour:
- Reset (async): all outputs 0. State IDLE. at_map=0, ct_map=0. LFSR=SEED. exp_cnt=NUM_FAULTS/EXP_DIV. cov_edge=COV_STEP. useless=0.
- States: IDLE, GEN, OFFER, SCAN, DECIDE, EMIT, DONE.
- IDLE: start -> GEN. At this transition clear counters, maps, useless, exp_cnt and cov_edge; busy=1, done=0. Keep the LFSR value.
- GEN: step 32-bit Galois LFSR (poly x^32+x^22+x^2+x+1) once per cycle. Shift each word into vec_data. Takes ceil(VEC_W/32) cycles; the top word is truncated. total_cnt++, then go to OFFER.
- OFFER: vec_valid=1, vec_data stable until vec_ready. On handshake: clear ct_map, idx=0, new_cnt=0, go to SCAN.
- SCAN: each det_valid cycle:
  - ct_map[idx]=det_bit.
  - If det_bit & !at_map[idx], new_cnt++.
  - idx++.
  - On det_last: go to DECIDE.
  - If det_last arrives with idx!=NUM_FAULTS-1, or idx reaches NUM_FAULTS without det_last: DONE, reason 2.
- DECIDE (1 cycle): keep = (new_cnt >= exp_cnt) && (new_cnt != 0).
  - Keep: at_map |= ct_map; det_total += new_cnt; kept_cnt++; useless=0. Then if det_total*100 >= cov_edge*NUM_FAULTS (no divider), cov_edge += COV_STEP and exp_cnt >>= 1 (at most one halving per vector). Go to EMIT.
  - Reject: useless++, then stop-check.
- EMIT: keep_valid=1 holding the vector until keep_ready, then stop-check.
- Stop-check:
  - det_total*100 >= DESIRED_COV*NUM_FAULTS -> DONE, reason 0.
  - Else useless >= UT_LIMIT -> DONE, reason 1.
  - Else GEN.
- DONE: busy=0, done=1. start -> restart as from IDLE.
- start while busy: ignored. det_valid outside SCAN: ignored. Reset mid-run: immediate abort to reset values; a partial vector is never emitted.
- Counters 16-bit saturate at 0xFFFF. exp_cnt floors at 0; when exp_cnt=0, any vector with new_cnt>0 is kept.

Decomposition:
- Package crtg_pkg: state enum, done_reason constants, LFSR polynomial constant, CW function.
- Sub-module crtg_lfsr32: seed load, enable, 32-bit word output.

Test Plan:
- NUM_FAULTS=8, EXP_DIV=4 (exp=2). Vector 1 detects faults 0,1,2 -> keep, det_total=3, kept_cnt=1, keep_valid with the same vec_data.
- Next vector detects only faults 1,2 (already known) -> new=0, reject, useless=1, no keep_valid.
- NUM_FAULTS=10, COV_STEP=10, exp=2. Vector detects 0,1 -> coverage 20% >= 10 -> exp=1, cov_edge=20. Next vector detects only fault 5 -> kept.
- UT_LIMIT=3, all det_bit=0 -> three rejects -> done=1, done_reason=1, total_cnt=3, kept_cnt=0.
- DESIRED_COV=90, NUM_FAULTS=10. Vector detects 0..8 -> det_total=9, done_reason=0 after keep_ready.
- det_last at idx 4 with NUM_FAULTS=8 -> done_reason=2. Separately, assert rst mid-SCAN -> all outputs 0 and IDLE next edge; keep_ready held low in EMIT stalls with keep_data stable.
